// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured PAT_W-bit pattern MSB-first for
// a programmable number of repetitions, with optional idle gaps between them.
module seq_pattern_tx #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [GAP_W-1:0] gap_n,
    input  logic             abort,
    output logic             x_out,
    output logic             x_valid,
    output logic             frame_last,
    output logic             busy,
    output logic             done
);
    localparam int BC_W = $clog2(PAT_W);
    localparam logic [BC_W-1:0] BC_TOP = BC_W'(PAT_W - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t           state, state_nx;
    logic [PAT_W-1:0] shreg, pat;
    logic [CNT_W-1:0] reps_left;
    logic [GAP_W-1:0] gap_rl, gap_cnt;
    logic [BC_W-1:0]  bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = SEND;
            SEND: if (bit_cnt == '0) begin
                if (reps_left <= CNT_W'(1)) state_nx = DONE;
                else if (gap_rl != '0)      state_nx = GAP;
            end
            GAP:  if (gap_cnt <= GAP_W'(1)) state_nx = SEND;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // abort overrides everything, including a start in the same cycle
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            pat       <= '0;
            reps_left <= '0;
            gap_rl    <= '0;
            gap_cnt   <= '0;
            bit_cnt   <= '0;
        end else if (!abort) begin
            case (state)
                IDLE: if (start) begin
                    shreg     <= pattern_in;
                    pat       <= pattern_in;
                    reps_left <= (repeat_n == '0) ? CNT_W'(1) : repeat_n;
                    gap_rl    <= gap_n;
                    bit_cnt   <= BC_TOP;
                end
                SEND: begin
                    if (bit_cnt == '0) begin
                        if (reps_left > CNT_W'(1)) begin
                            reps_left <= reps_left - CNT_W'(1);
                            shreg     <= pat;
                            bit_cnt   <= BC_TOP;
                            gap_cnt   <= gap_rl;
                        end
                    end else begin
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt - BC_W'(1);
                    end
                end
                GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
                default: ;
            endcase
        end
    end

    // Outputs are pure decodes of flops, so reset clears them immediately.
    assign x_valid    = (state == SEND);
    assign x_out      = x_valid & shreg[PAT_W-1];
    assign frame_last = x_valid & (bit_cnt == '0);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

endmodule
